// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative 32-bit multiply/divide unit for the MIPS core.
//               Runs MULT/MULTU as a radix-2 shift-add and DIV/DIVU as a
//               restoring divide on operand magnitudes. Each operation takes
//               a fixed 33-cycle latency. The result is returned as a
//               one-cycle write pulse on the register file's HI/LO port.
// Ports       : clk              - system clock, rising edge
//               reset            - asynchronous active-low reset
//               start            - request strobe, sampled while idle
//               op               - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//               operand_a        - rs (multiplicand / dividend)
//               operand_b        - rt (multiplier / divisor)
//               abort            - pipeline flush, cancels work in flight
//               busy             - operation in flight
//               HI/LO_write_enable - one-cycle write pulse, always paired
//               HI_write_data    - product[63:32] or remainder
//               LO_write_data    - product[31:0] or quotient
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
  parameter int ITERATIONS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        abort,
  output logic        busy,
  output logic        HI_write_enable,
  output logic        LO_write_enable,
  output logic [31:0] HI_write_data,
  output logic [31:0] LO_write_data
);

  localparam int c_cnt_w = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(ITERATIONS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ITER  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_count;
  logic                 r_is_div;
  logic                 r_a_neg;
  logic                 r_b_neg;
  logic [31:0]          r_a;      // dividend magnitude, kept for divide-by-zero
  logic [31:0]          r_b;      // multiplicand (mult) or divisor (div) magnitude
  logic [31:0]          r_hi;     // upper partial product / partial remainder
  logic [31:0]          r_lo;     // multiplier bits shifting out / quotient bits shifting in
  logic                 r_busy;
  logic                 r_hi_we;
  logic                 r_lo_we;
  logic [31:0]          r_hi_data;
  logic [31:0]          r_lo_data;

  // Operand magnitudes and signs at issue; unsigned ops never flag a sign.
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_accept;

  assign w_a_neg  = ~op[0] & operand_a[31];
  assign w_b_neg  = ~op[0] & operand_b[31];
  assign w_a_mag  = w_a_neg ? (32'd0 - operand_a) : operand_a;
  assign w_b_mag  = w_b_neg ? (32'd0 - operand_b) : operand_b;

  // A request is taken while idle, and also in the WRITE cycle so that
  // back-to-back operations issue every 34 cycles. Abort always wins.
  assign w_accept = start & ~abort & ((r_state == ST_IDLE) | (r_state == ST_WRITE));

  // Multiply step: add the multiplicand into the upper half when the current
  // multiplier bit is set, then shift the 64-bit pair right by one.
  logic [31:0] w_addend;
  logic [32:0] w_sum;

  assign w_addend = r_lo[0] ? r_b : 32'd0;
  assign w_sum    = {1'b0, r_hi} + {1'b0, w_addend};

  // Divide step: shift the next dividend bit into the partial remainder and
  // keep the difference only if it did not borrow. The shifted value may need
  // 33 bits, but whenever the subtraction is rejected it is below the divisor
  // and so fits back into 32 bits.
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_fits;

  assign w_shift = {r_hi, r_lo[31]};
  assign w_diff  = w_shift - {1'b0, r_b};
  assign w_fits  = ~w_diff[32];

  // Sign correction applied in FIXUP.
  logic        w_sign_diff;
  logic [63:0] w_prod_neg;
  logic [31:0] w_hi_res;
  logic [31:0] w_lo_res;

  assign w_sign_diff = r_a_neg ^ r_b_neg;
  assign w_prod_neg  = 64'd0 - {r_hi, r_lo};

  always_comb begin
    w_hi_res = r_hi;
    w_lo_res = r_lo;
    if (!r_is_div) begin
      if (w_sign_diff) begin
        w_hi_res = w_prod_neg[63:32];
        w_lo_res = w_prod_neg[31:0];
      end
    end else if (r_b == 32'd0) begin
      // Divide by zero: hand back the original dividend and all-ones.
      w_hi_res = r_a_neg ? (32'd0 - r_a) : r_a;
      w_lo_res = 32'hFFFF_FFFF;
    end else begin
      // Quotient negative when signs differ; remainder follows the dividend.
      w_lo_res = w_sign_diff ? (32'd0 - r_lo) : r_lo;
      w_hi_res = r_a_neg     ? (32'd0 - r_hi) : r_hi;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_is_div  <= 1'b0;
      r_a_neg   <= 1'b0;
      r_b_neg   <= 1'b0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_busy    <= 1'b0;
      r_hi_we   <= 1'b0;
      r_lo_we   <= 1'b0;
      r_hi_data <= 32'd0;
      r_lo_data <= 32'd0;
    end else begin
      // Enables are pulses: only FIXUP raises them, for exactly one cycle.
      r_hi_we <= 1'b0;
      r_lo_we <= 1'b0;

      case (r_state)
        ST_IDLE, ST_WRITE: begin
          if (w_accept) begin
            r_state  <= ST_ITER;
            r_count  <= '0;
            r_busy   <= 1'b1;
            r_is_div <= op[1];
            r_a_neg  <= w_a_neg;
            r_b_neg  <= w_b_neg;
            r_a      <= w_a_mag;
            r_hi     <= 32'd0;
            if (op[1]) begin
              r_b  <= w_b_mag;
              r_lo <= w_a_mag;
            end else begin
              r_b  <= w_a_mag;
              r_lo <= w_b_mag;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_ITER: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_count <= '0;
          end else begin
            if (r_is_div) begin
              r_hi <= w_fits ? w_diff[31:0] : w_shift[31:0];
              r_lo <= {r_lo[30:0], w_fits};
            end else begin
              r_hi <= w_sum[32:1];
              r_lo <= {w_sum[0], r_lo[31:1]};
            end
            if (r_count == c_last_step) begin
              r_state <= ST_FIXUP;
              r_count <= '0;
            end else begin
              r_count <= r_count + c_cnt_w'(1);
            end
          end
        end

        ST_FIXUP: begin
          r_busy <= 1'b0;
          if (abort) begin
            r_state <= ST_IDLE;
          end else begin
            r_state   <= ST_WRITE;
            r_hi_we   <= 1'b1;
            r_lo_we   <= 1'b1;
            r_hi_data <= w_hi_res;
            r_lo_data <= w_lo_res;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = r_busy;
  assign HI_write_enable = r_hi_we;
  assign LO_write_enable = r_lo_we;
  assign HI_write_data   = r_hi_data;
  assign LO_write_data   = r_lo_data;

endmodule
`default_nettype wire
